// File: rtl/fakeram_arbiter_2x1.sv
// Two-port round-robin front end for one single-port fakeram with a registered read.
// Each port owns one response slot; read data returns two cycles after the grant.
module fakeram_arbiter_2x1 #(
  parameter int BITS       = 128,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  p0_req_valid,
  output logic                  p0_req_ready,
  input  logic                  p0_req_we,
  input  logic [ADDR_WIDTH-1:0] p0_req_addr,
  input  logic [BITS-1:0]       p0_req_wd,
  output logic                  p0_rsp_valid,
  input  logic                  p0_rsp_ready,
  output logic [BITS-1:0]       p0_rsp_data,

  input  logic                  p1_req_valid,
  output logic                  p1_req_ready,
  input  logic                  p1_req_we,
  input  logic [ADDR_WIDTH-1:0] p1_req_addr,
  input  logic [BITS-1:0]       p1_req_wd,
  output logic                  p1_rsp_valid,
  input  logic                  p1_rsp_ready,
  output logic [BITS-1:0]       p1_rsp_data,

  output logic                  ram_ce,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [BITS-1:0]       ram_wd,
  input  logic [BITS-1:0]       ram_rd
);

  logic            ptr;
  logic [1:0]      vld_p1;
  logic [1:0]      vld_p2;
  logic [BITS-1:0] data0_p2;
  logic [BITS-1:0] data1_p2;

  logic            elig0;
  logic            elig1;
  logic            gnt0;
  logic            gnt1;

  // Stage 0: eligibility, round-robin grant and RAM command
  always_comb begin
    elig0 = p0_req_valid && (p0_req_we || (!vld_p2[0] && !vld_p1[0]));
    elig1 = p1_req_valid && (p1_req_we || (!vld_p2[1] && !vld_p1[1]));
    gnt0  = !reset && elig0 && (!elig1 || !ptr);
    gnt1  = !reset && elig1 && (!elig0 ||  ptr);
  end

  assign p0_req_ready = gnt0;
  assign p1_req_ready = gnt1;

  always_comb begin
    ram_ce   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = '0;
    ram_wd   = '0;
    if (gnt0) begin
      ram_ce   = 1'b1;
      ram_we   = p0_req_we;
      ram_addr = p0_req_addr;
      ram_wd   = p0_req_wd;
    end else if (gnt1) begin
      ram_ce   = 1'b1;
      ram_we   = p1_req_we;
      ram_addr = p1_req_addr;
      ram_wd   = p1_req_wd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= 1'b0;
    end else if (gnt0) begin
      ptr <= 1'b1;
    end else if (gnt1) begin
      ptr <= 1'b0;
    end
  end

  // Stage 1: read in flight, RAM is producing data this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1 <= 2'b00;
    end else begin
      vld_p1 <= {gnt1 && !p1_req_we, gnt0 && !p0_req_we};
    end
  end

  // Stage 2: per-port response slot, held until the consumer takes it
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p2   <= 2'b00;
      data0_p2 <= '0;
      data1_p2 <= '0;
    end else begin
      if (vld_p1[0]) begin
        vld_p2[0] <= 1'b1;
        data0_p2  <= ram_rd;
      end else if (vld_p2[0] && p0_rsp_ready) begin
        vld_p2[0] <= 1'b0;
      end
      if (vld_p1[1]) begin
        vld_p2[1] <= 1'b1;
        data1_p2  <= ram_rd;
      end else if (vld_p2[1] && p1_rsp_ready) begin
        vld_p2[1] <= 1'b0;
      end
    end
  end

  assign p0_rsp_valid = vld_p2[0];
  assign p1_rsp_valid = vld_p2[1];
  assign p0_rsp_data  = data0_p2;
  assign p1_rsp_data  = data1_p2;

endmodule
